// File: rtl/stats_pkg.sv
// stats_pkg: shared types and constants for the score/lives controller
package stats_pkg;
   typedef enum logic [2:0] {IDLE, ADD_1, ADD_10, ADD_100, LIFE} state_t;
   typedef logic [3:0] bcd_digit_t;
   localparam int LIVES_W = 3;
   localparam bcd_digit_t SCORE_SAT = 4'd9;
endpackage

// File: rtl/stats_controller_bcd_digit_add.sv
// bcd_digit_add: one BCD digit plus addend plus carry-in, giving digit and carry-out
//   i_digit  : current BCD digit (0..9)
//   i_addend : addend (0..9)
//   i_cin    : carry-in
//   o_sum    : resulting BCD digit
//   o_cout   : carry into the next digit
module bcd_digit_add
   import stats_pkg::*;
(
   input  bcd_digit_t i_digit,
   input  bcd_digit_t i_addend,
   input  logic       i_cin,
   output bcd_digit_t o_sum,
   output logic       o_cout
);
   logic [4:0] w_raw;
   logic [4:0] w_adj;
   assign w_raw  = {1'b0, i_digit} + {1'b0, i_addend} + {4'b0000, i_cin};
   assign w_adj  = w_raw - 5'd10;
   assign o_cout = w_raw >= 5'd10;
   assign o_sum  = o_cout ? w_adj[3:0] : w_raw[3:0];
endmodule

// File: rtl/stats_controller.sv
// stats_controller: owns score (3 BCD digits) and lives, arbitrates add/life requests, publishes at frame start
//   CLK, RESET (async, active-high)
//   NEW_GAME, FRAME_START          : one-cycle pulses
//   ADD_REQ/ADD_POINTS -> ADD_ACK  : score-add handshake (ACK is the accept-cycle pulse)
//   LIFE_REQ -> LIFE_ACK           : life-lost handshake, wins over ADD_REQ
//   SCORE_100/SCORE_10/SCORE_1/LIVES : frame-synchronous displayed values
//   GAME_OVER, BUSY                : working status
// Optional: define STATS_EXTRA_LIFE_EN to award a life on every carry into hundreds.
module stats_controller
   import stats_pkg::*;
#(
   parameter int INITIAL_LIVES = 3,
   parameter int MAX_LIVES     = 7
)(
   input  logic               CLK,
   input  logic               RESET,
   input  logic               NEW_GAME,
   input  logic               FRAME_START,
   input  logic               ADD_REQ,
   input  logic [3:0]         ADD_POINTS,
   output logic               ADD_ACK,
   input  logic               LIFE_REQ,
   output logic               LIFE_ACK,
   output logic [3:0]         SCORE_100,
   output logic [3:0]         SCORE_10,
   output logic [3:0]         SCORE_1,
   output logic [LIVES_W-1:0] LIVES,
   output logic               GAME_OVER,
   output logic               BUSY
);
   localparam logic [LIVES_W-1:0] L_INIT = LIVES_W'(INITIAL_LIVES);
   localparam logic [LIVES_W-1:0] L_MAX  = LIVES_W'(MAX_LIVES);
   state_t             r_state, w_next;
   bcd_digit_t         r_d100, r_d10, r_d1, r_addend;
   bcd_digit_t         r_disp100, r_disp10, r_disp1;
   logic [LIVES_W-1:0] r_lives, r_disp_lives, w_lives_up;
   logic               r_cin, r_carry, r_game_over;
   logic               w_idle, w_add_acc, w_life_acc, w_copy, w_bonus;
   bcd_digit_t         w_a, w_b, w_sum;
   logic               w_ci, w_cout;
   bcd_digit_add u_add (
      .i_digit  (w_a),
      .i_addend (w_b),
      .i_cin    (w_ci),
      .o_sum    (w_sum),
      .o_cout   (w_cout)
   );
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) r_state <= IDLE;
      else       r_state <= w_next;
   always_comb begin
      w_idle     = r_state == IDLE;
      w_life_acc = w_idle & LIFE_REQ & ~NEW_GAME & ~RESET;
      w_add_acc  = w_idle & ADD_REQ & ~LIFE_REQ & ~NEW_GAME & ~RESET;
      w_copy     = FRAME_START & w_idle & ~w_life_acc & ~w_add_acc & ~NEW_GAME;
      w_next     = IDLE;
      if (!NEW_GAME)
         unique case (r_state)
            IDLE:    w_next = w_life_acc ? LIFE : w_add_acc ? ADD_1 : IDLE;
            ADD_1:   w_next = ADD_10;
            ADD_10:  w_next = ADD_100;
            default: w_next = IDLE;
         endcase
      // single adder shared by the three digit states
      w_a        = (r_state == ADD_1) ? r_d1 : (r_state == ADD_10) ? r_d10 : r_d100;
      w_b        = (r_state == ADD_1) ? r_addend : (r_state == ADD_10) ? {3'b000, r_cin} : '0;
      w_ci       = (r_state != ADD_1) & r_carry;
      w_lives_up = (r_lives < L_MAX) ? r_lives + 3'd1 : r_lives;
`ifdef STATS_EXTRA_LIFE_EN
      // carry into hundreds that does not saturate earns a life
      w_bonus    = (r_state == ADD_100) & r_carry & ~w_cout & ~r_game_over;
`else
      w_bonus    = 1'b0;
`endif
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         {r_d100, r_d10, r_d1} <= '0;
         r_addend              <= '0;
         r_cin                 <= 1'b0;
         r_carry               <= 1'b0;
         r_lives               <= L_INIT;
         r_game_over           <= 1'b0;
      end else if (NEW_GAME) begin
         {r_d100, r_d10, r_d1} <= '0;
         r_carry               <= 1'b0;
         r_lives               <= L_INIT;
         r_game_over           <= 1'b0;
      end else begin
         if (w_add_acc) begin
            r_addend <= (ADD_POINTS >= 4'd10) ? ADD_POINTS - 4'd10 : ADD_POINTS;
            r_cin    <= ADD_POINTS >= 4'd10;
         end
         unique case (r_state)
            ADD_1: begin
               r_carry <= w_cout;
               if (!r_game_over) r_d1 <= w_sum;
            end
            ADD_10: begin
               r_carry <= w_cout;
               if (!r_game_over) r_d10 <= w_sum;
            end
            ADD_100: begin
               if (!r_game_over) begin
                  if (w_cout) {r_d100, r_d10, r_d1} <= {3{SCORE_SAT}};
                  else        r_d100 <= w_sum;
               end
               if (w_bonus) r_lives <= w_lives_up;
            end
            LIFE:
               if (!r_game_over && r_lives != '0) begin
                  r_lives <= r_lives - 3'd1;
                  if (r_lives == 3'd1) r_game_over <= 1'b1;
               end
            default: ;
         endcase
      end
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         {r_disp100, r_disp10, r_disp1} <= '0;
         r_disp_lives                   <= L_INIT;
      end else if (w_copy) begin
         {r_disp100, r_disp10, r_disp1} <= {r_d100, r_d10, r_d1};
         r_disp_lives                   <= r_lives;
      end
   end
   assign ADD_ACK   = w_add_acc;
   assign LIFE_ACK  = w_life_acc;
   assign SCORE_100 = r_disp100;
   assign SCORE_10  = r_disp10;
   assign SCORE_1   = r_disp1;
   assign LIVES     = r_disp_lives;
   assign GAME_OVER = r_game_over;
   assign BUSY      = r_state != IDLE;
endmodule
